// File: rtl/yarvi_wb.sv
// yarvi_wb: register-file writeback arbiter merging unstallable ALU results with FIFO-buffered load results,
// plus a pending-load scoreboard and a sticky write-after-write error flag.
module yarvi_wb #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     ex_valid,
    input  logic [4:0]               ex_rd,
    input  logic [XLEN-1:0]          ex_val,
    input  logic                     lsu_valid,
    input  logic [4:0]               lsu_rd,
    input  logic [XLEN-1:0]          lsu_val,
    output logic                     lsu_ready,
    input  logic                     iss_valid,
    input  logic [4:0]               iss_rd,
    output logic [4:0]               wb_rd,
    output logic [XLEN-1:0]          wb_val,
    output logic [31:0]              busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     err
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]     count_q, count_d;
    logic [4:0]      rd_q [DEPTH];
    logic [4:0]      rd_d [DEPTH];
    logic [XLEN-1:0] val_q [DEPTH];
    logic [XLEN-1:0] val_d [DEPTH];
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_val_q, wb_val_d;
    logic [31:0]     busy_q, busy_d;
    logic            err_q, err_d;
    logic            full, ex_wr, push, pop;

    assign full       = count_q == (AW+1)'(DEPTH);
    assign lsu_ready  = !full;
    assign wb_rd      = wb_rd_q;
    assign wb_val     = wb_val_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;
    assign err        = err_q;

    always_comb begin
        ex_wr = ex_valid && ex_rd != 5'd0;
        // Loads to x0 complete the handshake but never occupy a slot.
        push  = lsu_valid && !full && lsu_rd != 5'd0;
        pop   = !ex_wr && count_q != '0;
        rd_d  = rd_q;
        val_d = val_q;
        if (push) begin
            rd_d[wptr_q]  = lsu_rd;
            val_d[wptr_q] = lsu_val;
        end
        wptr_d   = wptr_q + AW'(push);
        rptr_d   = rptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
        wb_rd_d  = ex_wr ? ex_rd : pop ? rd_q[rptr_q] : 5'd0;
        wb_val_d = ex_wr ? ex_val : pop ? val_q[rptr_q] : wb_val_q;
        // Clear before set so a same-cycle reissue keeps the register pending.
        busy_d = busy_q;
        if (pop) busy_d[rd_q[rptr_q]] = 1'b0;
        if (iss_valid) busy_d[iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
        err_d = err_q | (ex_wr && busy_q[ex_rd]) | (push && !busy_q[lsu_rd]);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            rd_q     <= '{default: '0};
            val_q    <= '{default: '0};
            wb_rd_q  <= '0;
            wb_val_q <= '0;
            busy_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            rd_q     <= rd_d;
            val_q    <= val_d;
            wb_rd_q  <= wb_rd_d;
            wb_val_q <= wb_val_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_yarvi_wb.sv
// tb_yarvi_wb: directed stimulus against a queue-based writeback model checked every cycle,
// with literal expectations at key points of each scenario.
module tb_yarvi_wb;
    localparam int XLEN  = 64;
    localparam int DEPTH = 2;

    logic                   clock = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   ex_valid = 1'b0, lsu_valid = 1'b0, iss_valid = 1'b0;
    logic [4:0]             ex_rd = '0, lsu_rd = '0, iss_rd = '0;
    logic [XLEN-1:0]        ex_val = '0, lsu_val = '0;
    logic                   lsu_ready, err;
    logic [4:0]             wb_rd;
    logic [XLEN-1:0]        wb_val;
    logic [31:0]            busy;
    logic [$clog2(DEPTH):0] fifo_count;

    int checks = 0;
    int failures = 0;

    yarvi_wb #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_val(ex_val),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_val(lsu_val), .lsu_ready(lsu_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .wb_rd(wb_rd), .wb_val(wb_val), .busy(busy), .fifo_count(fifo_count), .err(err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an ordered queue of accepted loads and a set of pending registers.
    typedef struct { logic [4:0] rd; logic [XLEN-1:0] val; } ent_t;
    ent_t            m_q[$];
    logic [4:0]      m_wb_rd;
    logic [XLEN-1:0] m_wb_val;
    logic [31:0]     m_busy;
    logic            m_err;
    logic            prev_stall;
    logic [4:0]      prev_rd;
    logic [XLEN-1:0] prev_val;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_wb_rd = 0; m_wb_val = 0; m_busy = 0; m_err = 0; prev_stall = 0;
        end else begin
            automatic bit alu = ex_valid && ex_rd != 0;
            automatic bit ready = m_q.size() < DEPTH;
            automatic bit accept = lsu_valid && ready;
            automatic logic [31:0] old_busy = m_busy;
            automatic ent_t h;
            if (prev_stall)
                chk("lsu_hold", {58'd0, lsu_valid, lsu_rd, lsu_val == prev_val}, {58'd0, 1'b1, prev_rd, 1'b1});
            if (alu && old_busy[ex_rd]) m_err = 1;
            if (accept && lsu_rd != 0 && !old_busy[lsu_rd]) m_err = 1;
            if (alu) begin
                m_wb_rd = ex_rd; m_wb_val = ex_val;
            end else if (m_q.size() > 0) begin
                h = m_q.pop_front();
                m_wb_rd = h.rd; m_wb_val = h.val;
                m_busy[h.rd] = 0;
            end else m_wb_rd = 0;
            if (accept && lsu_rd != 0) m_q.push_back('{lsu_rd, lsu_val});
            if (iss_valid) m_busy[iss_rd] = 1;
            m_busy[0] = 0;
            prev_stall = lsu_valid && !ready;
            prev_rd = lsu_rd; prev_val = lsu_val;
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            chk("m_wb_rd", 64'(wb_rd), 64'(m_wb_rd));
            chk("m_wb_val", wb_val, m_wb_val);
            chk("m_busy", 64'(busy), 64'(m_busy));
            chk("m_count", 64'(fifo_count), 64'(m_q.size()));
            chk("m_ready", 64'(lsu_ready), 64'(m_q.size() < DEPTH));
            chk("m_err", 64'(err), 64'(m_err));
        end
    end

    task automatic idle();
        ex_valid = 0; lsu_valid = 0; iss_valid = 0;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        idle();
        reset_n = 0;
        tick(2);
        reset_n = 1;
    endtask

    initial begin
        do_reset();
        chk("rst_wb_rd", 64'(wb_rd), 0);
        chk("rst_wb_val", wb_val, 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_count", 64'(fifo_count), 0);
        chk("rst_ready", 64'(lsu_ready), 1);
        chk("rst_err", 64'(err), 0);

        // ALU write then bubble
        ex_valid = 1; ex_rd = 5; ex_val = 64'h1234;
        tick(); idle();
        chk("t1_wb_rd", 64'(wb_rd), 5);
        chk("t1_wb_val", wb_val, 64'h1234);
        tick();
        chk("t1_idle_rd", 64'(wb_rd), 0);
        chk("t1_idle_val", wb_val, 64'h1234);

        // single issued load
        iss_valid = 1; iss_rd = 7;
        tick(); idle();
        chk("t2_busy7", 64'(busy[7]), 1);
        lsu_valid = 1; lsu_rd = 7; lsu_val = 64'hAA;
        chk("t2_ready", 64'(lsu_ready), 1);
        tick(); idle();
        chk("t2_count1", 64'(fifo_count), 1);
        tick();
        chk("t2_wb_rd", 64'(wb_rd), 7);
        chk("t2_wb_val", wb_val, 64'hAA);
        chk("t2_busy7_clr", 64'(busy[7]), 0);

        // FIFO fills behind ALU stream, then drains in order
        for (int r = 3; r <= 5; r++) begin
            iss_valid = 1; iss_rd = 5'(r); tick();
        end
        idle();
        chk("t3_busy", 64'(busy), 64'h38);
        ex_valid = 1; ex_rd = 1; ex_val = 64'h11;
        lsu_valid = 1; lsu_rd = 3; lsu_val = 64'h33; tick();
        lsu_rd = 4; lsu_val = 64'h44; tick();
        chk("t3_count2", 64'(fifo_count), 2);
        chk("t3_full", 64'(lsu_ready), 0);
        lsu_rd = 5; lsu_val = 64'h55; tick();
        chk("t3_still2", 64'(fifo_count), 2);
        chk("t3_alu_rd", 64'(wb_rd), 1);
        ex_valid = 0; tick();
        chk("t3_wb3", 64'(wb_rd), 3);
        chk("t3_val3", wb_val, 64'h33);
        tick(); lsu_valid = 0;
        chk("t3_wb4", 64'(wb_rd), 4);
        chk("t3_cnt_pp", 64'(fifo_count), 1);
        tick();
        chk("t3_wb5", 64'(wb_rd), 5);
        chk("t3_val5", wb_val, 64'h55);
        chk("t3_empty", 64'(fifo_count), 0);
        chk("t3_busy_clr", 64'(busy), 0);
        chk("t3_err", 64'(err), 0);

        // async reset with a full FIFO and pending loads
        iss_valid = 1; iss_rd = 3; tick();
        iss_rd = 4; tick(); iss_valid = 0;
        ex_valid = 1; ex_rd = 1; ex_val = 64'h77;
        lsu_valid = 1; lsu_rd = 3; lsu_val = 64'h3; tick();
        lsu_rd = 4; lsu_val = 64'h4; tick();
        chk("t4_count2", 64'(fifo_count), 2);
        #2 reset_n = 0;
        #1;
        chk("t4_async_count", 64'(fifo_count), 0);
        chk("t4_async_busy", 64'(busy), 0);
        chk("t4_async_rd", 64'(wb_rd), 0);
        chk("t4_async_val", wb_val, 0);
        chk("t4_async_ready", 64'(lsu_ready), 1);
        idle(); tick(2); reset_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_no_stale", 64'(wb_rd), 0);
        end

        // load to x0 is swallowed
        lsu_valid = 1; lsu_rd = 0; lsu_val = 64'hDEAD;
        chk("t5_ready", 64'(lsu_ready), 1);
        tick(); idle();
        chk("t5_count", 64'(fifo_count), 0);
        chk("t5_wb_rd", 64'(wb_rd), 0);
        chk("t5_err", 64'(err), 0);
        tick();
        chk("t5_wb_rd2", 64'(wb_rd), 0);

        // WAW error, and reissue colliding with a pop
        iss_valid = 1; iss_rd = 9; tick(); idle();
        chk("t6_busy9", 64'(busy[9]), 1);
        ex_valid = 1; ex_rd = 9; ex_val = 64'h99; tick(); idle();
        chk("t6_wb_rd", 64'(wb_rd), 9);
        chk("t6_wb_val", wb_val, 64'h99);
        chk("t6_err", 64'(err), 1);
        lsu_valid = 1; lsu_rd = 9; lsu_val = 64'h999; tick(); idle();
        chk("t6_count", 64'(fifo_count), 1);
        iss_valid = 1; iss_rd = 9; tick(); idle();
        chk("t6_pop_rd", 64'(wb_rd), 9);
        chk("t6_pop_val", wb_val, 64'h999);
        chk("t6_busy_kept", 64'(busy[9]), 1);
        chk("t6_err_sticky", 64'(err), 1);

        // load result with no matching issue flags an error
        do_reset();
        chk("t7_err0", 64'(err), 0);
        lsu_valid = 1; lsu_rd = 12; lsu_val = 64'hC; tick(); idle();
        chk("t7_err", 64'(err), 1);
        tick();
        chk("t7_wb_rd", 64'(wb_rd), 12);
        chk("t7_wb_val", wb_val, 64'hC);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
